parking_sensor_gen: RTL and testbench
=====================================

// Module: parking_sensor_gen
// PURPOSE
// - Drives the two parking-lane beam sensors (a = outer beam, b = inner beam) with legal car-passage sequences.
// - Feeds the entry/exit detector in simulation and board bring-up, replacing real sensors.
// - One command produces one car passage (entry or exit) with a programmable dwell per phase.
// - A car that backs out part-way is modelled by an abort that replays the phases in reverse.
// PARAMETERS
// - DWELL_W  8  width of cmd_dwell and the internal dwell counter
// PORTS
// - clk        in   1        single clock, rising edge
// - rst_n      in   1        asynchronous, active-low reset
// - cmd_valid  in   1        command request
// - cmd_ready  out  1        block can accept a command
// - cmd_dir    in   1        0 = entry, 1 = exit; sampled on accept
// - cmd_dwell  in   DWELL_W  cycles each phase is held; 0 is treated as 1; sampled on accept
// - abort      in   1        car backs out; reverses the sequence
// - a          out  1        outer sensor (1 = beam blocked)
// - b          out  1        inner sensor (1 = beam blocked)
// - busy       out  1        a passage or reversal is in progress
// - done       out  1        1-cycle pulse: passage completed
// - aborted    out  1        1-cycle pulse: reversal completed
// BEHAVIOUR
// - Reset (asynchronous, takes effect immediately, including mid-passage):
//   - a=b=busy=done=aborted=0; state IDLE; dwell counter cleared; held command discarded.
//   - cmd_ready=1 from the first cycle after reset deasserts.
// - Phase patterns as {b,a}:
//   - entry: P1=01, P2=11, P3=10
//   - exit:  P1=10, P2=11, P3=01
//   - IDLE=00
// - All outputs are registered; cmd_ready = (state==IDLE).
// - Accept: cmd_valid && cmd_ready on a clock edge.
//   - The next cycle shows P1 with busy=1.
//   - cmd_valid while busy is ignored; no queueing.
// - Each phase is held for exactly D = max(cmd_dwell,1) cycles.
//   - Forward order: P1 -> P2 -> P3 -> IDLE.
//   - On the cycle a/b return to 00: done=1, busy=0, cmd_ready=1.
// - Back-to-back commands:
//   - A command accepted in the done cycle shows P1 on the following cycle.
//   - This guarantees at least 1 cycle of 00 between cars.
// - abort (sampled only while busy and moving forward):
//   - In P1 -> next cycle IDLE (00), aborted=1, no done.
//   - In P2 -> reverse to P1 (held D), then IDLE with aborted=1.
//   - In P3 -> reverse to P2, then P1 (each held D), then IDLE with aborted=1.
//   - The reverse step starts the cycle after abort is sampled; the remaining dwell of the current phase is discarded.
//   - abort while already reversing, or while in IDLE, is ignored.
//   - abort in the last dwell cycle of P3 takes priority over completion: reverse, no done.
// - done and aborted never assert in the same cycle.
// - a/b change on at most one bit per transition; no illegal 01<->10 step.
// - Dwell counter: DWELL_W bits.
//   - Loaded with D-1 on phase entry; phase advances when the counter reaches 0.
//   - No wrap-around.
// STRUCTURE
// - parking_pkg:
//   - typedef enum {IDLE,P1,P2,P3} sensor_phase_t
//   - localparams ENTRY_PAT[1:3] and EXIT_PAT[1:3] as {b,a}
//   - direction localparams DIR_ENTRY=0, DIR_EXIT=1
//   - shared with the detector.
// - Sub-module parking_dwell_timer: load / count-down / zero flag, DWELL_W wide.
// - Top level: one FSM (phase + forward/reverse flag), latched dir and dwell, output pattern register.
// TESTING
// - Entry, D=2: accept at cycle 0.
//   - {b,a} = 01,01,11,11,10,10,00 on cycles 1-7.
//   - done=1 in cycle 7 only.
// - Exit, D=1: {b,a} = 10,11,01,00 on cycles 1-4; done in cycle 4.
// - Entry, D=3, abort in 2nd cycle of P2:
//   - {b,a} = 01x3, 11x2, 01x3, 00.
//   - aborted=1 in the 00 cycle; done stays 0.
// - Back-to-back: second command valid in the done cycle.
//   - Exactly one 00 cycle between passages; cmd_valid during busy is ignored.
// - cmd_dwell=0: each phase lasts 1 cycle, identical to D=1.
// - rst_n low mid-P2: a=b=0 immediately, before the next clk edge.
//   - cmd_ready=1 after release; a stale cmd_valid=0 starts nothing.

Source files
------------

// File: rtl/parking_pkg.sv
// Shared definitions for the parking-lane sensor generator and the
// entry/exit detector.
//   sensor_phase_t   : phase of a car passage (IDLE, P1, P2, P3)
//   fsm_state_t      : generator FSM state (phase + reversing flag),
//                      kept as one struct so checkers can bind to it
//   ENTRY_PAT/EXIT_PAT : {b,a} sensor pattern for P1..P3
//   DIR_ENTRY/DIR_EXIT : command direction encoding
//   phase_pat()      : {b,a} pattern for a given direction and phase
package parking_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    P1   = 2'd1,
    P2   = 2'd2,
    P3   = 2'd3
  } sensor_phase_t;

  typedef struct packed {
    sensor_phase_t phase;
    logic          rev;    // 1 = replaying phases backwards after an abort
  } fsm_state_t;

  localparam logic DIR_ENTRY = 1'b0;
  localparam logic DIR_EXIT  = 1'b1;

  // Patterns are {b,a}: a = outer beam, b = inner beam.
  localparam logic [1:0] ENTRY_PAT [1:3] = '{2'b01, 2'b11, 2'b10};
  localparam logic [1:0] EXIT_PAT  [1:3] = '{2'b10, 2'b11, 2'b01};

  function automatic logic [1:0] phase_pat(input logic dir, input sensor_phase_t ph);
    logic [1:0] pat;
    pat = 2'b00;
    case (ph)
      P1:      pat = (dir == DIR_EXIT) ? EXIT_PAT[1] : ENTRY_PAT[1];
      P2:      pat = (dir == DIR_EXIT) ? EXIT_PAT[2] : ENTRY_PAT[2];
      P3:      pat = (dir == DIR_EXIT) ? EXIT_PAT[3] : ENTRY_PAT[3];
      default: pat = 2'b00;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/parking_dwell_timer.sv
// Phase dwell timer: loads a start value and counts down to zero, then
// holds at zero (never wraps).
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : load load_val this cycle (wins over counting)
//   load_val   : value to load (phase length minus one)
//   zero       : counter is at zero (current cycle is the last of the phase)
module parking_dwell_timer #(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [DWELL_W-1:0] load_val,
  output logic               zero
);

  logic [DWELL_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - DWELL_W'(1);
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/parking_sensor_gen.sv
// Parking-lane beam sensor generator. One accepted command plays one car
// passage on the outer (a) and inner (b) beam sensors, each phase held for
// max(cmd_dwell,1) cycles. An abort during the forward sequence replays the
// visited phases in reverse, modelling a car that backs out.
//   clk, rst_n : clock, asynchronous active-low reset
//   cmd_valid / cmd_ready : command handshake
//   cmd_dir    : 0 entry, 1 exit (sampled on accept)
//   cmd_dwell  : cycles per phase, 0 treated as 1 (sampled on accept)
//   abort      : start a reversal (only while moving forward)
//   a, b       : outer / inner beam, 1 = blocked (registered)
//   busy       : passage or reversal in progress (registered)
//   done       : 1-cycle pulse when a passage completes (registered)
//   aborted    : 1-cycle pulse when a reversal completes (registered)
//
// Handshake: a command transfers on a rising edge where cmd_valid and
// cmd_ready are both 1. cmd_ready is high exactly while the FSM is IDLE; a
// command offered while busy is not stored and has no effect.
module parking_sensor_gen
  import parking_pkg::*;
#(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_dir,
  input  logic [DWELL_W-1:0] cmd_dwell,
  input  logic               abort,
  output logic               a,
  output logic               b,
  output logic               busy,
  output logic               done,
  output logic               aborted
);

  fsm_state_t         st_q, st_d;
  logic               dir_q, dir_d;
  logic [DWELL_W-1:0] dm1_q, dm1_d;     // latched phase length minus one
  logic [1:0]         pat_q;            // {b,a}
  logic               busy_q, done_q, aborted_q;
  logic               done_d, aborted_d;
  logic               load;
  logic [DWELL_W-1:0] load_val;
  logic               zero;

  parking_dwell_timer #(.DWELL_W(DWELL_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .load_val (load_val),
    .zero     (zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q      <= '{phase: IDLE, rev: 1'b0};
      dir_q     <= DIR_ENTRY;
      dm1_q     <= '0;
      pat_q     <= 2'b00;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      st_q      <= st_d;
      dir_q     <= dir_d;
      dm1_q     <= dm1_d;
      // Outputs are registered from the next state so they line up with it.
      pat_q     <= phase_pat(dir_d, st_d.phase);
      busy_q    <= (st_d.phase != IDLE);
      done_q    <= done_d;
      aborted_q <= aborted_d;
    end
  end

  always_comb begin
    st_d      = st_q;
    dir_d     = dir_q;
    dm1_d     = dm1_q;
    load      = 1'b0;
    load_val  = dm1_q;
    done_d    = 1'b0;
    aborted_d = 1'b0;

    case (st_q.phase)
      IDLE: begin
        if (cmd_valid) begin
          st_d.phase = P1;
          st_d.rev   = 1'b0;
          dir_d      = cmd_dir;
          dm1_d      = (cmd_dwell == '0) ? '0 : cmd_dwell - DWELL_W'(1);
          load       = 1'b1;
          load_val   = dm1_d;
        end
      end
      default: begin
        if (!st_q.rev && abort) begin
          // Abort beats normal advance, including the last cycle of P3;
          // the remaining dwell of the current phase is dropped.
          case (st_q.phase)
            P1: begin
              st_d.phase = IDLE;
              aborted_d  = 1'b1;
            end
            P2: begin
              st_d.phase = P1;
              st_d.rev   = 1'b1;
              load       = 1'b1;
            end
            default: begin
              st_d.phase = P2;
              st_d.rev   = 1'b1;
              load       = 1'b1;
            end
          endcase
        end else if (zero) begin
          if (!st_q.rev) begin
            case (st_q.phase)
              P1: begin
                st_d.phase = P2;
                load       = 1'b1;
              end
              P2: begin
                st_d.phase = P3;
                load       = 1'b1;
              end
              default: begin
                st_d.phase = IDLE;
                done_d     = 1'b1;
              end
            endcase
          end else begin
            // Reversal only ever visits P2 and P1.
            if (st_q.phase == P1) begin
              st_d.phase = IDLE;
              st_d.rev   = 1'b0;
              aborted_d  = 1'b1;
            end else begin
              st_d.phase = P1;
              load       = 1'b1;
            end
          end
        end
      end
    endcase
  end

  assign cmd_ready = (st_q.phase == IDLE);
  assign a         = pat_q[0];
  assign b         = pat_q[1];
  assign busy      = busy_q;
  assign done      = done_q;
  assign aborted   = aborted_q;

endmodule

// File: tb/tb_parking_sensor_gen.sv
module tb_parking_sensor_gen;

  localparam int DWELL_W = 8;

  logic               clk;
  logic               rst_n;
  logic               cmd_valid;
  logic               cmd_ready;
  logic               cmd_dir;
  logic [DWELL_W-1:0] cmd_dwell;
  logic               abort;
  logic               a, b, busy, done, aborted;

  int tests_run;
  int tests_failed;

  parking_sensor_gen #(.DWELL_W(DWELL_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_dir   (cmd_dir),
    .cmd_dwell (cmd_dwell),
    .abort     (abort),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .aborted   (aborted)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, want completion");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer a command before the next edge; returns in cycle 1 with valid low.
  task automatic send_cmd(input logic dir, input logic [DWELL_W-1:0] dwell);
    cmd_valid = 1'b1;
    cmd_dir   = dir;
    cmd_dwell = dwell;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cmd_valid = 1'b0; cmd_dir = 1'b0; cmd_dwell = '0; abort = 1'b0;
    #3;
    tests_run++;
    if ({b, a, busy, done, aborted} !== 5'b0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got %b want 00000", {b, a, busy, done, aborted});
    end
    step(); step();
    rst_n = 1'b1;
    step();
    tests_run++;
    if (cmd_ready !== 1'b1 || {b, a} !== 2'b00 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_release: ready=%b ba=%b busy=%b want 1 00 0", cmd_ready, {b, a}, busy);
    end
  endtask

  task automatic test_entry_d2();
    logic [1:0] e [0:6] = '{2'b01, 2'b01, 2'b11, 2'b11, 2'b10, 2'b10, 2'b00};
    send_cmd(1'b0, 8'd2);
    for (int i = 0; i < 7; i++) begin
      tests_run++;
      if ({b, a} !== e[i] || done !== (i == 6) || busy !== (i < 6) || aborted !== 1'b0) begin
        tests_failed++;
        $display("FAIL entry_d2 cycle %0d: ba=%b done=%b busy=%b ab=%b want ba=%b done=%b busy=%b ab=0",
                 i + 1, {b, a}, done, busy, aborted, e[i], (i == 6), (i < 6));
      end
      step();
    end
    tests_run++;
    if (done !== 1'b0 || cmd_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL entry_d2 after: done=%b ready=%b want 0 1", done, cmd_ready);
    end
  endtask

  task automatic test_exit_d1();
    logic [1:0] e [0:3] = '{2'b10, 2'b11, 2'b01, 2'b00};
    send_cmd(1'b1, 8'd1);
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if ({b, a} !== e[i] || done !== (i == 3) || cmd_ready !== (i == 3)) begin
        tests_failed++;
        $display("FAIL exit_d1 cycle %0d: ba=%b done=%b ready=%b want ba=%b done=%b ready=%b",
                 i + 1, {b, a}, done, cmd_ready, e[i], (i == 3), (i == 3));
      end
      step();
    end
  endtask

  task automatic test_dwell_zero();
    logic [1:0] e [0:3] = '{2'b10, 2'b11, 2'b01, 2'b00};
    send_cmd(1'b1, 8'd0);
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if ({b, a} !== e[i] || done !== (i == 3)) begin
        tests_failed++;
        $display("FAIL dwell_zero cycle %0d: ba=%b done=%b want ba=%b done=%b",
                 i + 1, {b, a}, done, e[i], (i == 3));
      end
      step();
    end
  endtask

  // Abort in 2nd cycle of P2; a second abort during the reversal is ignored.
  task automatic test_abort_p2();
    logic [1:0] e [0:8] = '{2'b01, 2'b01, 2'b01, 2'b11, 2'b11, 2'b01, 2'b01, 2'b01, 2'b00};
    send_cmd(1'b0, 8'd3);
    for (int i = 0; i < 9; i++) begin
      tests_run++;
      if ({b, a} !== e[i] || aborted !== (i == 8) || done !== 1'b0 || busy !== (i < 8)) begin
        tests_failed++;
        $display("FAIL abort_p2 cycle %0d: ba=%b aborted=%b done=%b busy=%b want ba=%b aborted=%b done=0 busy=%b",
                 i + 1, {b, a}, aborted, done, busy, e[i], (i == 8), (i < 8));
      end
      abort = (i == 4) || (i == 6);
      step();
    end
    abort = 1'b0;
    tests_run++;
    if (aborted !== 1'b0 || {b, a} !== 2'b00) begin
      tests_failed++;
      $display("FAIL abort_p2 after: aborted=%b ba=%b want 0 00", aborted, {b, a});
    end
  endtask

  // Abort in the last (only) cycle of P3 beats completion.
  task automatic test_abort_p3_last();
    logic [1:0] e [0:5] = '{2'b10, 2'b11, 2'b01, 2'b11, 2'b10, 2'b00};
    send_cmd(1'b1, 8'd1);
    for (int i = 0; i < 6; i++) begin
      tests_run++;
      if ({b, a} !== e[i] || aborted !== (i == 5) || done !== 1'b0) begin
        tests_failed++;
        $display("FAIL abort_p3 cycle %0d: ba=%b aborted=%b done=%b want ba=%b aborted=%b done=0",
                 i + 1, {b, a}, aborted, done, e[i], (i == 5));
      end
      abort = (i == 2);
      step();
    end
    abort = 1'b0;
  endtask

  task automatic test_abort_p1();
    send_cmd(1'b0, 8'd2);
    tests_run++;
    if ({b, a} !== 2'b01) begin
      tests_failed++;
      $display("FAIL abort_p1 start: ba=%b want 01", {b, a});
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    tests_run++;
    if ({b, a} !== 2'b00 || aborted !== 1'b1 || done !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_p1 end: ba=%b aborted=%b done=%b busy=%b want 00 1 0 0",
               {b, a}, aborted, done, busy);
    end
    step();
  endtask

  task automatic test_back_to_back();
    logic [1:0] e [0:8] = '{2'b01, 2'b11, 2'b10, 2'b00, 2'b10, 2'b11, 2'b01, 2'b00, 2'b00};
    send_cmd(1'b0, 8'd1);
    for (int i = 0; i < 9; i++) begin
      tests_run++;
      if ({b, a} !== e[i] || done !== (i == 3 || i == 7) || busy !== !(i == 3 || i >= 7)) begin
        tests_failed++;
        $display("FAIL back_to_back cycle %0d: ba=%b done=%b busy=%b want ba=%b done=%b busy=%b",
                 i + 1, {b, a}, done, busy, e[i], (i == 3 || i == 7), !(i == 3 || i >= 7));
      end
      // Second command offered in the done cycle; valid then stays high
      // (with the other direction) while busy and must be ignored.
      if (i == 3) begin cmd_valid = 1'b1; cmd_dir = 1'b1; cmd_dwell = 8'd1; end
      if (i == 4) cmd_dir = 1'b0;
      if (i == 6) cmd_valid = 1'b0;
      step();
    end
  endtask

  task automatic test_reset_mid();
    send_cmd(1'b0, 8'd4);
    for (int i = 0; i < 4; i++) step();
    tests_run++;
    if ({b, a} !== 2'b11) begin
      tests_failed++;
      $display("FAIL reset_mid pre: ba=%b want 11", {b, a});
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({b, a} !== 2'b00 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_mid async: ba=%b busy=%b want 00 0", {b, a}, busy);
    end
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      tests_run++;
      if (cmd_ready !== 1'b1 || {b, a} !== 2'b00 || busy !== 1'b0 || done !== 1'b0) begin
        tests_failed++;
        $display("FAIL reset_mid after %0d: ready=%b ba=%b busy=%b done=%b want 1 00 0 0",
                 i, cmd_ready, {b, a}, busy, done);
      end
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_entry_d2();
    test_exit_d1();
    test_dwell_zero();
    test_abort_p2();
    test_abort_p3_last();
    test_abort_p1();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
